// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: two-stage pipelined 2**SEL_W:1 mux (half-trees in S1, final 2:1 in S2), latency 2, one beat/cycle.
// out_ready stalls S2, then S1, then in_ready; `define MUX_TREE_SCAN_EN adds scan_mode/scan_idx counter-driven select.
module mux_tree_pipe #(
  parameter int W     = 1,
  parameter int SEL_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [(2**SEL_W)*W-1:0]   in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef MUX_TREE_SCAN_EN
  input  logic                      scan_mode,
  output logic [SEL_W-1:0]          scan_idx,
`endif
  output logic [W-1:0]              out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int N    = 2**SEL_W;
  localparam int HALF = N / 2;

  logic             live_q, live_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_lo_q, s1_lo_d;
  logic [W-1:0]     s1_hi_q, s1_hi_d;
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_data_q, s2_data_d;
  logic [SEL_W-1:0] s2_sel_q, s2_sel_d;

  logic [SEL_W-1:0] beat_sel;
  logic [W-1:0]     lo_mux, hi_mux;
  logic             accept;
  logic             s2_load;

  // live_q keeps in_ready low during reset and for the release cycle
  assign in_ready = live_q && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign s2_load  = !s2_valid_q || out_ready;

`ifdef MUX_TREE_SCAN_EN
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    beat_sel = scan_mode ? cnt_q : in_sel;
    cnt_d    = cnt_q;
    if (accept && scan_mode) cnt_d = cnt_q + SEL_W'(1);
  end

  assign scan_idx = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign beat_sel = in_sel;
`endif

  // The low select bits pick the same slot in both halves; the top bit is resolved in S2
  always_comb begin
    lo_mux = '0;
    hi_mux = '0;
    for (int k = 0; k < HALF; k++) begin
      if (beat_sel[SEL_W-2:0] == (SEL_W-1)'(k)) begin
        lo_mux = in_data[k*W +: W];
        hi_mux = in_data[(k+HALF)*W +: W];
      end
    end
  end

  always_comb begin
    live_d     = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    s1_sel_d   = s1_sel_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sel_d   = s2_sel_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      s1_lo_d    = lo_mux;
      s1_hi_d    = hi_mux;
      s1_sel_d   = beat_sel;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_sel_q[SEL_W-1] ? s1_hi_q : s1_lo_q;
      s2_sel_d   = s1_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s1_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sel_q   <= '0;
    end else begin
      live_q     <= live_d;
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sel_q   <= s2_sel_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sel   = s2_sel_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: directed scenarios plus a randomized run against a queue-based reference model.
module tb_mux_tree_pipe;
  localparam int W     = 8;
  localparam int SEL_W = 4;
  localparam int N     = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;

  logic [3:0]       s_in_data;
  logic [1:0]       s_in_sel;
  logic             s_in_valid;
  logic             s_in_ready;
  logic             s_out_data;
  logic [1:0]       s_out_sel;
  logic             s_out_valid;
  logic             s_out_ready;

`ifdef MUX_TREE_SCAN_EN
  logic             scan_mode;
  logic [SEL_W-1:0] scan_idx;
  logic             s_scan_mode;
  logic [1:0]       s_scan_idx;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]     d;
    logic [SEL_W-1:0] s;
    int               t;
  } beat_t;

  always #5 clk = ~clk;

  mux_tree_pipe #(.W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_TREE_SCAN_EN
    .scan_mode (scan_mode),
    .scan_idx  (scan_idx),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_tree_pipe #(.W(1), .SEL_W(2)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_in_data),
    .in_sel    (s_in_sel),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
`ifdef MUX_TREE_SCAN_EN
    .scan_mode (s_scan_mode),
    .scan_idx  (s_scan_idx),
`endif
    .out_data  (s_out_data),
    .out_sel   (s_out_sel),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready)
  );

  task automatic set_ramp();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'(k + 16);
  endtask

  task automatic test_reset();
    in_valid    = 1'b0;
    in_sel      = 4'd3;
    out_ready   = 1'b1;
    s_in_data   = 4'b1010;
    s_in_sel    = 2'd0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
`ifdef MUX_TREE_SCAN_EN
    scan_mode   = 1'b0;
    s_scan_mode = 1'b0;
`endif
    set_ramp();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 || out_sel !== 4'h0) begin
      failures++;
      $display("FAIL reset_state got ov=%b ir=%b od=%h os=%h want 0 0 00 0", out_valid, in_ready, out_data, out_sel);
    end
`ifdef MUX_TREE_SCAN_EN
    checks++;
    if (scan_idx !== 4'h0) begin
      failures++;
      $display("FAIL reset_scan_idx got %h want 0", scan_idx);
    end
`endif
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_in_ready_low got %b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready_high got %b/%b want 1/1", in_ready, s_in_ready);
    end
  endtask

`ifdef MUX_TREE_SCAN_EN
  task automatic test_scan();
    out_ready = 1'b1;
    scan_mode = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk);
      #1;
      in_valid = (c < 18);
      in_sel   = 4'($urandom);
      @(negedge clk);
      if (c >= 2 && c < 20) begin
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 4'((c - 2) % N) || out_data !== 8'(16 + (c - 2) % N)) begin
          failures++;
          $display("FAIL scan_seq c=%0d got ov=%b os=%h od=%h want 1 %h %h", c, out_valid, out_sel, out_data,
                   4'((c - 2) % N), 8'(16 + (c - 2) % N));
        end
      end
    end
    checks++;
    if (scan_idx !== 4'd2) begin
      failures++;
      $display("FAIL scan_idx_final got %h want 2", scan_idx);
    end
    scan_mode = 1'b0;
  endtask
`endif

  task automatic test_single();
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_sel = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_accept in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h15 || out_sel !== 4'd5) begin
      failures++;
      $display("FAIL single_result got ov=%b od=%h os=%h want 1 15 5", out_valid, out_data, out_sel);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      in_valid = (c < 16);
      in_sel   = 4'(c);
      @(negedge clk);
      if (c < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready c=%0d got %b want 1", c, in_ready);
        end
      end
      checks++;
      if (c >= 2 && c < 18) begin
        if (out_valid !== 1'b1 || out_data !== 8'(16 + c - 2) || out_sel !== 4'(c - 2)) begin
          failures++;
          $display("FAIL b2b_out c=%0d got ov=%b od=%h os=%h want 1 %h %h", c, out_valid, out_data, out_sel,
                   8'(16 + c - 2), 4'(c - 2));
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle c=%0d out_valid got %b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept0 in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_sel = 4'd1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept1 in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_sel = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h10 || out_sel !== 4'd0) begin
        failures++;
        $display("FAIL bp_hold i=%0d got ir=%b ov=%b od=%h os=%h want 0 1 10 0", i, in_ready, out_valid, out_data, out_sel);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (i < 3) begin
        if (out_valid !== 1'b1 || out_data !== 8'(16 + i) || out_sel !== 4'(i)) begin
          failures++;
          $display("FAIL bp_drain i=%0d got ov=%b od=%h os=%h want 1 %h %h", i, out_valid, out_data, out_sel,
                   8'(16 + i), 4'(i));
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_duplicate out_valid got %b want 0", out_valid);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd3;
    @(posedge clk);
    #1 in_sel = 4'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got ov=%b ir=%b want 0 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b1; in_sel = 4'd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (c < 2) begin
        if (out_valid !== 1'b0 || (c == 0 && in_ready !== 1'b1)) begin
          failures++;
          $display("FAIL midreset_stale c=%0d got ov=%b ir=%b want 0 1", c, out_valid, in_ready);
        end
      end else if (out_valid !== 1'b1 || out_data !== 8'h19 || out_sel !== 4'd9) begin
        failures++;
        $display("FAIL midreset_next got ov=%b od=%h os=%h want 1 19 9", out_valid, out_data, out_sel);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic test_small();
    logic [3:0] pattern;
    pattern = 4'b1010;
    s_in_data = pattern;
    s_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      s_in_valid = (c < 4);
      s_in_sel   = 2'(c);
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== pattern[c-2] || s_out_sel !== 2'(c - 2)) begin
          failures++;
          $display("FAIL small_out c=%0d got ov=%b od=%b os=%0d want 1 %b %0d", c, s_out_valid, s_out_data, s_out_sel,
                   pattern[c-2], c - 2);
        end
      end
    end
    s_in_valid = 1'b0;
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic  exp_rdy;
    logic  exp_vld;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = 4'($urandom);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'($urandom);
      @(negedge clk);
      exp_rdy = (q.size() < 2) || out_ready;
      exp_vld = (q.size() > 0) && (cyc - q[0].t >= 2);
      checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_vld) begin
        failures++;
        $display("FAIL rand_handshake cyc=%0d got ir=%b ov=%b want %b %b", cyc, in_ready, out_valid, exp_rdy, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (out_data !== q[0].d || out_sel !== q[0].s) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got od=%h os=%h want %h %h", cyc, out_data, out_sel, q[0].d, q[0].s);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        b.d = in_data[in_sel*W +: W];
        b.s = in_sel;
        b.t = cyc;
        q.push_back(b);
      end
    end
    in_valid = 1'b0;
    set_ramp();
  endtask

  initial begin
    test_reset();
`ifdef MUX_TREE_SCAN_EN
    test_scan();
`endif
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_small();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
